// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared types and constants for the RV32I load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = LSU_DATA_WIDTH / 8;

  // RV32I Funct3 width/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } lsu_state_t;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Brief    : Combinational legality check, store lane steering / strobe
//             generation and load byte/half extraction with extension.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic                  is_write,
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  input  logic [31:0]           store_data,
  input  logic [31:0]           load_word,
  output logic [31:0]           wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic [31:0]           load_data,
  output logic                  legal
);

  logic [31:0] load_shifted;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Pick the addressed byte lane and halfword lane out of the response word
  always_comb begin
    load_shifted = load_word >> {off, 3'b000};
    load_byte    = load_shifted[7:0];
    load_half    = off[1] ? load_word[31:16] : load_word[15:0];
  end

  // Legality: unsigned codes exist only for loads; H/W need natural alignment
  always_comb begin
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~off[0];
      F3_W:    legal = (off == 2'b00);
      F3_BU:   legal = ~is_write;
      F3_HU:   legal = ~is_write & ~off[0];
      default: legal = 1'b0;
    endcase
  end

  // Store steering: replicate the narrow operand across lanes, strobe the target lanes
  always_comb begin
    wdata = store_data;
    wstrb = '0;
    if (is_write) begin
      case (funct3)
        F3_B: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << off;
        end
        F3_H: begin
          wdata = {2{store_data[15:0]}};
          wstrb = 4'b0011 << off;
        end
        F3_W:    wstrb = 4'b1111;
        default: wstrb = '0;
      endcase
    end
  end

  // Load extension: signed codes replicate the top bit, unsigned codes pad with zero
  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_BU:   load_data = {24'd0, load_byte};
      F3_HU:   load_data = {16'd0, load_half};
      default: load_data = load_word;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : Multi-cycle data-memory access unit: request FSM, operand
//             latching and load-result register between execute and a
//             valid/ready data memory.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReq,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  AccessErr,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  a_we;
  logic [2:0]            a_f3;
  logic [1:0]            a_off;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [STRB_WIDTH-1:0] a_wstrb;
  logic [DATA_WIDTH-1:0] a_load;
  logic                  a_legal;

  // In IDLE the aligner looks at the live request; afterwards at the latched one
  always_comb begin
    a_we  = (state_q == S_IDLE) ? MemWrite   : we_q;
    a_f3  = (state_q == S_IDLE) ? Funct3     : f3_q;
    a_off = (state_q == S_IDLE) ? Addr[1:0]  : off_q;
  end

  lsu_align u_align (
    .is_write   (a_we),
    .funct3     (a_f3),
    .off        (a_off),
    .store_data (WriteData),
    .load_word  (mem_rdata),
    .wdata      (a_wdata),
    .wstrb      (a_wstrb),
    .load_data  (a_load),
    .legal      (a_legal)
  );

  // Next-state and operand-latch logic for the access sequence
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (MemReq) begin
          if (a_legal) begin
            we_d    = MemWrite;
            f3_d    = Funct3;
            off_d   = Addr[1:0];
            addr_d  = {Addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = a_wdata;
            wstrb_d = a_wstrb;
            err_d   = 1'b0;
            state_d = S_REQ;
          end else begin
            // Illegal access skips the memory entirely
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) state_d = we_q ? S_DONE : S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (mem_rvalid) begin
          rdata_d = a_load;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are decodes of registered state; only Stall follows MemReq directly
  always_comb begin
    mem_valid = (state_q == S_REQ);
    mem_we    = mem_valid & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
    Done      = (state_q == S_DONE);
    AccessErr = Done & err_q;
    ReadData  = rdata_q;
    Stall     = MemReq & (state_q != S_DONE);
  end

endmodule : load_store_unit
`default_nettype wire
